// File: rtl/btn_trigger.sv
// btn_trigger: synchronizes and debounces a push-button, then turns each
// accepted press into a fixed-length active pulse followed by a cooldown
// window in which further presses are ignored.
module btn_trigger #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 33_554_432,
  parameter int COOLDOWN_CYCLES = 117_440_512
) (
  input  logic clk,
  input  logic reset,      // synchronous, active-low
  input  logic btn_in,     // raw asynchronous button level
  output logic active,
  output logic btn_level,
  output logic busy
);

  // One counter width covers the largest terminal count of the three.
  localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_P  = (MAX_DH > COOLDOWN_CYCLES) ? MAX_DH : COOLDOWN_CYCLES;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] DEB_TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_TERM = CNT_W'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_deb_cnt;
  logic             r_btn_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_cool_cnt;
  logic             r_active;
  logic             r_busy;
  state_t           r_state;
  state_t           w_state_next;
  logic             w_press;

  // Two-flop synchronizer: the only place btn_in is sampled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept the new level only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement; any return to the current level restarts the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_deb_cnt   <= '0;
      r_btn_level <= 1'b0;
    end else if (r_sync2 == r_btn_level) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_TERM) begin
      r_btn_level <= r_sync2;
      r_deb_cnt   <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_btn_level;
    end
  end

  // Only a 0->1 debounced transition counts as a press; releases are ignored.
  assign w_press = r_btn_level & ~r_level_d;

  // State register plus registered outputs derived from the next state,
  // so active/busy change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_active <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_active <= (w_state_next == S_HOLD);
      r_busy   <= (w_state_next != S_IDLE);
    end
  end

  // Next-state logic; presses outside IDLE are simply dropped.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:     if (w_press) w_state_next = S_HOLD;
      S_HOLD:     if (r_hold_cnt == HOLD_TERM) w_state_next = S_COOLDOWN;
      S_COOLDOWN: if (r_cool_cnt == COOL_TERM) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // HOLD counter: zero outside HOLD, counts up while in HOLD and saturates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hold_cnt <= '0;
    end else if (r_state != S_HOLD) begin
      r_hold_cnt <= '0;
    end else if (r_hold_cnt != HOLD_TERM) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  // COOLDOWN counter: zero outside COOLDOWN, counts up and saturates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cool_cnt <= '0;
    end else if (r_state != S_COOLDOWN) begin
      r_cool_cnt <= '0;
    end else if (r_cool_cnt != COOL_TERM) begin
      r_cool_cnt <= r_cool_cnt + 1'b1;
    end
  end

  assign active    = r_active;
  assign btn_level = r_btn_level;
  assign busy      = r_busy;

endmodule

// File: tb/tb_btn_trigger.sv
// Directed bench for btn_trigger. Cycle n below means the value observed
// just after the n-th rising edge counted from 1, where the stimulus for
// edge e (starting at e = 0) is applied before that edge.
module tb_btn_trigger;

  logic clk = 1'b0;
  logic rst_a, btn_a, act_a, lvl_a, busy_a;
  logic rst_b, btn_b, act_b, lvl_b, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic tr_act  [0:63];
  logic tr_busy [0:63];
  logic tr_lvl  [0:63];

  always #5 clk = ~clk;

  btn_trigger #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (8),
    .COOLDOWN_CYCLES(6)
  ) u_dut_a (
    .clk      (clk),
    .reset    (rst_a),
    .btn_in   (btn_a),
    .active   (act_a),
    .btn_level(lvl_a),
    .busy     (busy_a)
  );

  btn_trigger #(
    .DEBOUNCE_CYCLES(1),
    .HOLD_CYCLES    (1),
    .COOLDOWN_CYCLES(1)
  ) u_dut_b (
    .clk      (clk),
    .reset    (rst_b),
    .btn_in   (btn_b),
    .active   (act_b),
    .btn_level(lvl_b),
    .busy     (busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_a();
    btn_a = 1'b0;
    rst_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b1;
  endtask

  // btn_in high for edges e < rel_e and e >= rep_e; reset low at edge rst_e.
  task automatic run_a(input int ncyc, input int rel_e, input int rep_e, input int rst_e);
    for (int e = 0; e < ncyc; e++) begin
      btn_a = (e < rel_e) || (e >= rep_e);
      rst_a = (e == rst_e) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      tr_act[e+1]  = act_a;
      tr_busy[e+1] = busy_a;
      tr_lvl[e+1]  = lvl_a;
    end
    rst_a = 1'b1;
  endtask

  // Compare traced active/busy against up to two expected windows each.
  task automatic check_trace(input string tag, input int ncyc,
                             input int a1l, input int a1h, input int a2l, input int a2h,
                             input int b1l, input int b1h, input int b2l, input int b2h);
    logic ea, eb;
    for (int n = 1; n <= ncyc; n++) begin
      ea = ((n >= a1l) && (n <= a1h)) || ((n >= a2l) && (n <= a2h));
      eb = ((n >= b1l) && (n <= b1h)) || ((n >= b2l) && (n <= b2h));
      chk($sformatf("%s_active_c%0d", tag, n), {31'd0, tr_act[n]}, {31'd0, ea});
      chk($sformatf("%s_busy_c%0d", tag, n), {31'd0, tr_busy[n]}, {31'd0, eb});
    end
  endtask

  initial begin
    logic seen_lvl, seen_act;
    rst_b = 1'b0;
    btn_b = 1'b0;

    // Reset holds everything low even with the button pressed.
    btn_a = 1'b1;
    rst_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_active", {31'd0, act_a}, 32'd0);
    chk("reset_busy", {31'd0, busy_a}, 32'd0);
    chk("reset_level", {31'd0, lvl_a}, 32'd0);
    $display("reset: active=%0b busy=%0b level=%0b", act_a, busy_a, lvl_a);

    // Single clean press held.
    reset_a();
    run_a(24, 1000, 1000, -1);
    chk("press_level_c5", {31'd0, tr_lvl[5]}, 32'd0);
    chk("press_level_c6", {31'd0, tr_lvl[6]}, 32'd1);
    check_trace("press", 24, 7, 14, 0, -1, 7, 20, 0, -1);
    $display("clean press: active 7..14, busy 7..20 checked");

    // Bouncing input never settles long enough.
    reset_a();
    seen_lvl = 1'b0;
    seen_act = 1'b0;
    for (int e = 0; e < 40; e++) begin
      btn_a = ((e / 2) % 2) == 1;
      @(posedge clk);
      #1;
      seen_lvl = seen_lvl | lvl_a;
      seen_act = seen_act | act_a;
    end
    chk("bounce_level", {31'd0, seen_lvl}, 32'd0);
    chk("bounce_active", {31'd0, seen_act}, 32'd0);
    $display("bounce: level_seen=%0b active_seen=%0b", seen_lvl, seen_act);

    // Second press whose debounced level rises during COOLDOWN is dropped.
    reset_a();
    run_a(40, 6, 12, -1);
    chk("cd_level_c12", {31'd0, tr_lvl[12]}, 32'd0);
    chk("cd_level_c18", {31'd0, tr_lvl[18]}, 32'd1);
    check_trace("cd", 40, 7, 14, 0, -1, 7, 20, 0, -1);
    $display("press in cooldown: discarded");

    // Held through COOLDOWN: no retrigger; release and re-press gives one pulse.
    reset_a();
    run_a(60, 30, 36, -1);
    chk("held_level_c36", {31'd0, tr_lvl[36]}, 32'd0);
    chk("held_level_c42", {31'd0, tr_lvl[42]}, 32'd1);
    check_trace("held", 60, 7, 14, 43, 50, 7, 20, 43, 56);
    $display("held then re-press: single new pulse 43..50");

    // Reset at the third HOLD cycle drops outputs at once; the still-held
    // button then produces a fresh debounced press after reset.
    reset_a();
    run_a(34, 1000, 1000, 9);
    check_trace("midrst", 34, 7, 9, 17, 24, 7, 9, 17, 30);
    $display("reset mid-hold: outputs dropped at cycle 10");

    // Minimum parameters: 1-cycle active, 2-cycle busy.
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    for (int e = 0; e < 10; e++) begin
      btn_b = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("min_active_c%0d", e + 1), {31'd0, act_b}, {31'd0, (e + 1) == 4});
      chk($sformatf("min_busy_c%0d", e + 1), {31'd0, busy_b},
          {31'd0, ((e + 1) >= 4) && ((e + 1) <= 5)});
    end
    $display("min params: active 1 cycle, busy 2 cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
